// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : UART (8N1) program loader framing big-endian 32-bit words into
//               instruction-memory writes; holds the CPU in reset while loading.
//               Define IMEM_LOADER_CHKSUM_EN to expect a trailing XOR checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  input  logic              start,
  output logic              wr_en,
  output logic [31:0]       wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              frame_err,
  output logic              chk_err
);

  localparam int                c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam logic [c_cnt_w-1:0] c_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [7:0]         c_hdr  = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
`ifdef IMEM_LOADER_CHKSUM_EN
    ST_CHK  = 3'd4,
`endif
    ST_FIN  = 3'd5
  } ld_state_t;

  // ---------------- byte receiver ----------------
  logic               r_rx_meta, r_rx_sync;
  rx_state_t          r_rx_state, w_rx_state_next;
  logic [c_cnt_w-1:0] r_clk_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_rx_shift;
  logic [7:0]         r_rx_byte;
  logic               r_byte_valid;
  logic               r_frame_bad;
  logic               w_cnt_clr, w_shift, w_stop_ok, w_stop_bad;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_state <= RX_IDLE;
    end else begin
      r_rx_meta  <= rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_state <= w_rx_state_next;
    end
  end

  always_comb begin
    w_rx_state_next = r_rx_state;
    w_cnt_clr       = 1'b0;
    w_shift         = 1'b0;
    w_stop_ok       = 1'b0;
    w_stop_bad      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (!r_rx_sync) begin
          w_rx_state_next = RX_START;
          w_cnt_clr       = 1'b1;
        end
      end
      RX_START: begin
        // a start bit that is high again at mid-bit was only a glitch
        if (r_clk_cnt == c_half) begin
          w_cnt_clr       = 1'b1;
          w_rx_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_clk_cnt == c_full) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_bit_idx == 3'd7) w_rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_clk_cnt == c_full) begin
          w_cnt_clr       = 1'b1;
          w_rx_state_next = RX_IDLE;
          w_stop_ok       = r_rx_sync;
          w_stop_bad      = !r_rx_sync;
        end
      end
      default: w_rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_clk_cnt    <= '0;
      r_bit_idx    <= 3'd0;
      r_rx_shift   <= 8'd0;
      r_rx_byte    <= 8'd0;
      r_byte_valid <= 1'b0;
      r_frame_bad  <= 1'b0;
    end else begin
      r_clk_cnt    <= w_cnt_clr ? '0 : r_clk_cnt + 1'b1;
      r_byte_valid <= w_stop_ok;
      r_frame_bad  <= w_stop_bad;
      if (r_rx_state == RX_START) r_bit_idx <= 3'd0;
      else if (w_shift)           r_bit_idx <= r_bit_idx + 3'd1;
      if (w_shift)   r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
      if (w_stop_ok) r_rx_byte  <= r_rx_shift;
    end
  end

  // ---------------- loader FSM ----------------
  ld_state_t          r_state, w_state_next;
  logic [23:0]        r_word;
  logic [1:0]         r_byte_idx;
  logic [7:0]         r_len;
  logic [7:0]         r_words_rx;
  logic [ADDR_W:0]    r_word_count;
  logic               r_wr_en, r_done, r_cpu_hold, r_frame_err;
  logic [31:0]        r_wr_addr, r_wr_data;
  logic               w_arm, w_take_len, w_take_data, w_word_done, w_finish;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]         r_xor;
  logic               r_chk_err;
  logic               w_fail_chk;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_arm        = 1'b0;
    w_take_len   = 1'b0;
    w_take_data  = 1'b0;
    w_word_done  = 1'b0;
    w_finish     = 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
    w_fail_chk   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_HDR;
          w_arm        = 1'b1;
        end
      end
      ST_HDR: begin
        if (r_byte_valid && r_rx_byte == c_hdr) w_state_next = ST_LEN;
      end
      ST_LEN: begin
        if (r_byte_valid) begin
          w_take_len = 1'b1;
          if (r_rx_byte != 8'd0) begin
            w_state_next = ST_DATA;
          end else begin
`ifdef IMEM_LOADER_CHKSUM_EN
            w_state_next = ST_CHK;
`else
            w_state_next = ST_FIN;
            w_finish     = 1'b1;
`endif
          end
        end
      end
      ST_DATA: begin
        if (r_byte_valid) begin
          w_take_data = 1'b1;
          if (r_byte_idx == 2'd3) begin
            w_word_done = 1'b1;
            if (r_words_rx + 8'd1 == r_len) begin
`ifdef IMEM_LOADER_CHKSUM_EN
              w_state_next = ST_CHK;
`else
              w_state_next = ST_FIN;
              w_finish     = 1'b1;
`endif
            end
          end
        end
      end
`ifdef IMEM_LOADER_CHKSUM_EN
      ST_CHK: begin
        if (r_byte_valid) begin
          if (r_rx_byte == r_xor) begin
            w_state_next = ST_FIN;
            w_finish     = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
            w_fail_chk   = 1'b1;
          end
        end
      end
`endif
      ST_FIN:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
    // a bad stop bit aborts any load in progress; cpu_hold is left set
    if (r_frame_bad && r_state != ST_IDLE) w_state_next = ST_IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_word       <= 24'd0;
      r_byte_idx   <= 2'd0;
      r_len        <= 8'd0;
      r_words_rx   <= 8'd0;
      r_word_count <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 32'd0;
      r_wr_data    <= 32'd0;
      r_done       <= 1'b0;
      r_cpu_hold   <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
      r_xor        <= 8'd0;
      r_chk_err    <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      if (r_frame_bad) r_frame_err <= 1'b1;
      if (w_arm) begin
        r_cpu_hold   <= 1'b1;
        r_word_count <= '0;
        r_frame_err  <= 1'b0;
        r_byte_idx   <= 2'd0;
        r_words_rx   <= 8'd0;
`ifdef IMEM_LOADER_CHKSUM_EN
        r_chk_err    <= 1'b0;
        r_xor        <= 8'd0;
`endif
      end
      if (w_take_len) begin
        r_len      <= r_rx_byte;
        r_byte_idx <= 2'd0;
        r_words_rx <= 8'd0;
      end
      if (w_take_data) begin
        r_word     <= {r_word[15:0], r_rx_byte};
        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
        r_xor      <= r_xor ^ r_rx_byte;
`endif
      end
      if (w_word_done) begin
        r_words_rx <= r_words_rx + 8'd1;
        // words beyond the memory depth are consumed without a write
        if (!r_word_count[ADDR_W]) begin
          r_wr_en      <= 1'b1;
          r_wr_addr    <= 32'(r_word_count) << 2;
          r_wr_data    <= {r_word, r_rx_byte};
          r_word_count <= r_word_count + 1'b1;
        end
      end
      if (w_finish) begin
        r_done     <= 1'b1;
        r_cpu_hold <= 1'b0;
      end
`ifdef IMEM_LOADER_CHKSUM_EN
      if (w_fail_chk) r_chk_err <= 1'b1;
`endif
    end
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign cpu_hold   = r_cpu_hold;
  assign done       = r_done;
  assign word_count = r_word_count;
  assign frame_err  = r_frame_err;
`ifdef IMEM_LOADER_CHKSUM_EN
  assign chk_err    = r_chk_err;
`else
  assign chk_err    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed bench for imem_loader (ADDR_W=8 and ADDR_W=2 copies).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int BIT = 8;
`ifdef IMEM_LOADER_CHKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx    = 1'b1;
  logic        start = 1'b0;

  logic        wr_en, cpu_hold, done, frame_err, chk_err;
  logic [31:0] wr_addr, wr_data;
  logic [8:0]  word_count;

  logic        wr_en2, cpu_hold2, done2, frame_err2, chk_err2;
  logic [31:0] wr_addr2, wr_data2;
  logic [2:0]  word_count2;

  int checks = 0;
  int failures = 0;

  int          wr_cnt, done_cnt, wr2_cnt, done2_cnt;
  logic        hold_at_done;
  logic [31:0] wa [0:7];
  logic [31:0] wd [0:7];
  logic [31:0] wa2 [0:7];
  logic [31:0] wd2 [0:7];
  logic [7:0]  tx [0:31];

  imem_loader #(.CLKS_PER_BIT(BIT), .ADDR_W(8)) dut (
    .clock(clock), .reset(reset), .rx(rx), .start(start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .word_count(word_count),
    .frame_err(frame_err), .chk_err(chk_err)
  );

  imem_loader #(.CLKS_PER_BIT(BIT), .ADDR_W(2)) dut2 (
    .clock(clock), .reset(reset), .rx(rx), .start(start),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .cpu_hold(cpu_hold2), .done(done2), .word_count(word_count2),
    .frame_err(frame_err2), .chk_err(chk_err2)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wr_en) begin
      if (wr_cnt < 8) begin wa[wr_cnt] = wr_addr; wd[wr_cnt] = wr_data; end
      wr_cnt = wr_cnt + 1;
    end
    if (done) begin
      done_cnt     = done_cnt + 1;
      hold_at_done = cpu_hold;
    end
    if (wr_en2) begin
      if (wr2_cnt < 8) begin wa2[wr2_cnt] = wr_addr2; wd2[wr2_cnt] = wr_data2; end
      wr2_cnt = wr2_cnt + 1;
    end
    if (done2) done2_cnt = done2_cnt + 1;
  end

  task automatic clear_logs();
    wr_cnt = 0; done_cnt = 0; wr2_cnt = 0; done2_cnt = 0; hold_at_done = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx = 1'b0; idle(BIT);
    for (int i = 0; i < 8; i++) begin rx = b[i]; idle(BIT); end
    rx = good_stop; idle(BIT);
    rx = 1'b1;
  endtask

  task automatic send_tx(input int n);
    for (int i = 0; i < n; i++) send_byte(tx[i], 1'b1);
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  // A5 02 12345678 DEADBEEF, data XOR = 2A
  task automatic load_std_frame(input logic [7:0] chk_byte);
    tx[0] = 8'hA5; tx[1] = 8'h02;
    tx[2] = 8'h12; tx[3] = 8'h34; tx[4] = 8'h56; tx[5] = 8'h78;
    tx[6] = 8'hDE; tx[7] = 8'hAD; tx[8] = 8'hBE; tx[9] = 8'hEF;
    tx[10] = chk_byte;
  endtask

  task automatic test_reset();
    if (wr_en !== 1'b0 || done !== 1'b0 || cpu_hold !== 1'b0) begin
      failures++; $display("FAIL reset_ctrl: wr_en=%b done=%b hold=%b want 000", wr_en, done, cpu_hold);
    end
    checks++;
    if (wr_addr !== 32'd0 || wr_data !== 32'd0) begin
      failures++; $display("FAIL reset_port: addr=%h data=%h want 0", wr_addr, wr_data);
    end
    checks++;
    if (word_count !== 9'd0 || frame_err !== 1'b0 || chk_err !== 1'b0) begin
      failures++; $display("FAIL reset_stat: wc=%0d fe=%b ce=%b want 0", word_count, frame_err, chk_err);
    end
    checks++;
  endtask

  task automatic test_basic_load();
    clear_logs();
    pulse_start();
    idle(2);
    if (cpu_hold !== 1'b1) begin failures++; $display("FAIL basic_hold_set: got %b want 1", cpu_hold); end
    checks++;
    load_std_frame(8'h2A);
    send_tx(CHK_ON ? 11 : 10);
    idle(20);
    if (wr_cnt !== 2) begin failures++; $display("FAIL basic_wr_cnt: got %0d want 2", wr_cnt); end
    checks++;
    if (wa[0] !== 32'h0 || wd[0] !== 32'h12345678) begin
      failures++; $display("FAIL basic_w0: addr=%h data=%h want 0/12345678", wa[0], wd[0]);
    end
    checks++;
    if (wa[1] !== 32'h4 || wd[1] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL basic_w1: addr=%h data=%h want 4/deadbeef", wa[1], wd[1]);
    end
    checks++;
    if (done_cnt !== 1) begin failures++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
    checks++;
    if (hold_at_done !== 1'b0) begin failures++; $display("FAIL basic_hold_at_done: got %b want 0", hold_at_done); end
    checks++;
    if (cpu_hold !== 1'b0 || word_count !== 9'd2 || chk_err !== 1'b0) begin
      failures++; $display("FAIL basic_end: hold=%b wc=%0d ce=%b want 0/2/0", cpu_hold, word_count, chk_err);
    end
    checks++;
  endtask

  task automatic test_chk_fail();
    clear_logs();
    pulse_start();
    load_std_frame(8'h3F);
    send_tx(11);
    idle(20);
    if (done_cnt !== (CHK_ON ? 0 : 1)) begin
      failures++; $display("FAIL chk_done: got %0d want %0d", done_cnt, CHK_ON ? 0 : 1);
    end
    checks++;
    if (chk_err !== CHK_ON || cpu_hold !== CHK_ON) begin
      failures++; $display("FAIL chk_flags: ce=%b hold=%b want %b/%b", chk_err, cpu_hold, CHK_ON, CHK_ON);
    end
    checks++;
    if (wr_cnt !== 2) begin failures++; $display("FAIL chk_writes: got %0d want 2", wr_cnt); end
    checks++;
  endtask

  task automatic test_hdr_noise();
    clear_logs();
    rx = 1'b0; idle(2); rx = 1'b1; idle(20);
    pulse_start();
    rx = 1'b0; idle(2); rx = 1'b1; idle(20);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    load_std_frame(8'h2A);
    send_tx(CHK_ON ? 11 : 10);
    idle(20);
    if (wr_cnt !== 2 || wd[0] !== 32'h12345678 || wd[1] !== 32'hDEADBEEF) begin
      failures++; $display("FAIL noise_writes: cnt=%0d d0=%h d1=%h want 2/12345678/deadbeef", wr_cnt, wd[0], wd[1]);
    end
    checks++;
    if (done_cnt !== 1 || cpu_hold !== 1'b0 || chk_err !== 1'b0) begin
      failures++; $display("FAIL noise_done: done=%0d hold=%b ce=%b want 1/0/0", done_cnt, cpu_hold, chk_err);
    end
    checks++;
  endtask

  // five words 01020304..11121314; XOR of bytes 1..20 is 0x14
  task automatic test_addr_limit();
    clear_logs();
    pulse_start();
    tx[0] = 8'hA5; tx[1] = 8'h05;
    for (int i = 0; i < 20; i++) tx[2+i] = 8'(i + 1);
    tx[22] = 8'h14;
    send_tx(CHK_ON ? 23 : 22);
    idle(20);
    if (wr2_cnt !== 4) begin failures++; $display("FAIL limit_wr_cnt: got %0d want 4", wr2_cnt); end
    checks++;
    for (int i = 0; i < 4; i++) begin
      if (wa2[i] !== 32'(i * 4)) begin
        failures++; $display("FAIL limit_addr%0d: got %h want %h", i, wa2[i], 32'(i * 4));
      end
      checks++;
    end
    if (wd2[3] !== 32'h0D0E0F10) begin failures++; $display("FAIL limit_data3: got %h want 0d0e0f10", wd2[3]); end
    checks++;
    if (done2_cnt !== 1 || word_count2 !== 3'd4 || cpu_hold2 !== 1'b0) begin
      failures++; $display("FAIL limit_end: done=%0d wc=%0d hold=%b want 1/4/0", done2_cnt, word_count2, cpu_hold2);
    end
    checks++;
    if (wr_cnt !== 5 || wd[4] !== 32'h11121314) begin
      failures++; $display("FAIL limit_full: cnt=%0d d4=%h want 5/11121314", wr_cnt, wd[4]);
    end
    checks++;
  endtask

  task automatic test_frame_err();
    clear_logs();
    pulse_start();
    load_std_frame(8'h2A);
    send_tx(4);
    send_byte(8'h56, 1'b0);
    idle(120);
    for (int i = 5; i < 10; i++) send_byte(tx[i], 1'b1);
    idle(20);
    if (frame_err !== 1'b1 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL ferr_flags: fe=%b hold=%b want 1/1", frame_err, cpu_hold);
    end
    checks++;
    if (wr_cnt !== 0 || done_cnt !== 0) begin
      failures++; $display("FAIL ferr_quiet: wr=%0d done=%0d want 0/0", wr_cnt, done_cnt);
    end
    checks++;
    pulse_start();
    idle(2);
    if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clear: got %b want 0", frame_err); end
    checks++;
    send_tx(CHK_ON ? 11 : 10);
    idle(20);
    if (done_cnt !== 1 || wr_cnt !== 2 || cpu_hold !== 1'b0) begin
      failures++; $display("FAIL ferr_reload: done=%0d wr=%0d hold=%b want 1/2/0", done_cnt, wr_cnt, cpu_hold);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    clear_logs();
    pulse_start();
    load_std_frame(8'h2A);
    send_tx(4);
    idle(10);
    if (cpu_hold !== 1'b1) begin failures++; $display("FAIL rmid_hold_before: got %b want 1", cpu_hold); end
    checks++;
    #2 reset = 1'b1;
    #1;
    if (cpu_hold !== 1'b0 || wr_data !== 32'd0 || wr_addr !== 32'd0 || word_count !== 9'd0) begin
      failures++; $display("FAIL rmid_async: hold=%b data=%h addr=%h wc=%0d want 0", cpu_hold, wr_data, wr_addr, word_count);
    end
    checks++;
    idle(3);
    reset = 1'b0;
    idle(3);
    clear_logs();
    pulse_start();
    send_tx(CHK_ON ? 11 : 10);
    idle(20);
    if (done_cnt !== 1 || wr_cnt !== 2 || wd[1] !== 32'hDEADBEEF || word_count !== 9'd2) begin
      failures++; $display("FAIL rmid_reload: done=%0d wr=%0d d1=%h wc=%0d want 1/2/deadbeef/2", done_cnt, wr_cnt, wd[1], word_count);
    end
    checks++;
  endtask

  initial begin
    clear_logs();
    idle(4);
    test_reset();
    reset = 1'b0;
    idle(4);
    test_basic_load();
    test_chk_fail();
    test_hdr_noise();
    test_addr_limit();
    test_frame_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
